// File: rtl/ws2812_frame_sched.sv
// rtl/ws2812_frame_sched.sv - WS2812B frame scheduler: pixel buffer, pixel streaming, latch gap and auto-refresh
`timescale 1ns/1ps

module ws2812_frame_sched #(
    parameter int NUM_LEDS       = 8,
    parameter int ADDR_W         = 3,
    parameter int LATCH_CYCLES   = 1350,
    parameter int REFRESH_CYCLES = 900000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [23:0]       wr_data,
    input  logic              frame_req,
    output logic              px_valid,
    output logic [23:0]       px_data,
    input  logic              px_ready,
    input  logic              ser_idle,
    output logic              busy,
    output logic              frame_done
);

    localparam int LT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
    localparam int RC_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam bit REFRESH_EN = (REFRESH_CYCLES > 0);

    localparam logic [ADDR_W-1:0] LAST_IDX     = ADDR_W'(NUM_LEDS - 1);
    localparam logic [ADDR_W:0]   NUM_IDX      = (ADDR_W + 1)'(NUM_LEDS);
    localparam logic [LT_W-1:0]   LATCH_LAST   = LT_W'(LATCH_CYCLES - 1);
    localparam logic [RC_W-1:0]   REFRESH_LAST = RC_W'((REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        DRAIN = 2'd2,
        LATCH = 2'd3
    } state_t;

    state_t              state;
    logic [23:0]         pix_buf [NUM_LEDS];
    logic [ADDR_W-1:0]   idx;
    logic [LT_W-1:0]     latch_cnt;
    logic [RC_W-1:0]     refresh_cnt;
    logic                pending;
    logic                drain_first;

    logic                wr_ok;
    logic                refresh_hit;
    logic                start;
    logic                handshake;
    logic [ADDR_W-1:0]   nxt_idx;

    assign wr_ok       = wr_en && ({1'b0, wr_addr} < NUM_IDX);
    assign refresh_hit = REFRESH_EN && (refresh_cnt == REFRESH_LAST);
    assign start       = (state == IDLE) && (frame_req || pending || refresh_hit);
    assign handshake   = px_valid && px_ready;
    assign nxt_idx     = idx + ADDR_W'(1);

    // Out-of-range addresses are dropped so the chain length stays fixed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                pix_buf[i] <= '0;
            end
        end else if (wr_ok) begin
            pix_buf[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            latch_cnt   <= '0;
            refresh_cnt <= '0;
            pending     <= 1'b0;
            drain_first <= 1'b0;
            px_valid    <= 1'b0;
            px_data     <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            // The refresh counter parks at its terminal value until a frame starts.
            if (start) begin
                refresh_cnt <= '0;
            end else if (REFRESH_EN && !refresh_hit) begin
                refresh_cnt <= refresh_cnt + RC_W'(1);
            end

            if (start) begin
                pending <= 1'b0;
            end else if (frame_req || refresh_hit) begin
                pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        idx      <= '0;
                        px_data  <= (wr_ok && (wr_addr == '0)) ? wr_data : pix_buf[0];
                        px_valid <= 1'b1;
                        busy     <= 1'b1;
                        state    <= SEND;
                    end
                end

                SEND: begin
                    if (handshake) begin
                        if (idx != LAST_IDX) begin
                            idx     <= nxt_idx;
                            // A write landing on the next pixel in this cycle is forwarded.
                            px_data <= (wr_ok && (wr_addr == nxt_idx)) ? wr_data : pix_buf[nxt_idx];
                        end else begin
                            px_valid    <= 1'b0;
                            drain_first <= 1'b1;
                            state       <= DRAIN;
                        end
                    end
                end

                DRAIN: begin
                    // ser_idle may still reflect the pre-handshake idle state on entry.
                    drain_first <= 1'b0;
                    if (!drain_first && ser_idle) begin
                        latch_cnt <= '0;
                        state     <= LATCH;
                    end
                end

                LATCH: begin
                    if (latch_cnt == LATCH_LAST) begin
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        latch_cnt <= latch_cnt + LT_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_frame_sched.sv
// tb/tb_ws2812_frame_sched.sv - scoreboard bench for ws2812_frame_sched
`timescale 1ns/1ps

module tb_ws2812_frame_sched;

    localparam int N   = 3;
    localparam int AW  = 2;
    localparam int LAT = 16;
    localparam int REF = 100;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [23:0]   wr_data = '0;
    logic          frame_req = 1'b0;
    logic          px_valid;
    logic [23:0]   px_data;
    logic          px_ready = 1'b1;
    logic          ser_idle = 1'b1;
    logic          busy;
    logic          frame_done;

    logic          r_px_valid;
    logic [23:0]   r_px_data;
    logic          r_busy;
    logic          r_frame_done;

    always #5 clk = ~clk;

    ws2812_frame_sched #(.NUM_LEDS(N), .ADDR_W(AW), .LATCH_CYCLES(LAT), .REFRESH_CYCLES(0)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_req(frame_req), .px_valid(px_valid), .px_data(px_data), .px_ready(px_ready),
        .ser_idle(ser_idle), .busy(busy), .frame_done(frame_done)
    );

    ws2812_frame_sched #(.NUM_LEDS(N), .ADDR_W(AW), .LATCH_CYCLES(LAT), .REFRESH_CYCLES(REF)) dut_r (
        .clk(clk), .rst_n(rst_n), .wr_en(1'b0), .wr_addr(2'd0), .wr_data(24'd0),
        .frame_req(1'b0), .px_valid(r_px_valid), .px_data(r_px_data), .px_ready(1'b1),
        .ser_idle(1'b1), .busy(r_busy), .frame_done(r_frame_done)
    );

    int checks = 0;
    int passes = 0;

    logic [23:0] mbuf [N];
    logic [23:0] exp_q [$];
    int          r_done_cyc [$];

    int cyc = 0;
    int hs_cnt = 0, done_cnt = 0;
    int last_hs_cyc = 0, done_cyc = 0, rise_cyc = 0, req_cyc = 0;
    logic prev_valid = 1'b0, prev_stall = 1'b0;
    logic [23:0] held = '0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the expected pixel on every handshake, independent of stimulus.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (px_valid && prev_stall) check("held px_data", px_data, held);
            if (px_valid && !prev_valid) rise_cyc = cyc;
            prev_stall = px_valid && !px_ready;
            prev_valid = px_valid;
            held       = px_data;
            if (px_valid && px_ready) begin
                hs_cnt++;
                last_hs_cyc = cyc;
                if (exp_q.size() == 0) check("unexpected pixel", 1, 0);
                else check("px_data", px_data, exp_q.pop_front());
            end
            if (frame_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (r_frame_done) r_done_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_px(input int addr, input logic [23:0] data);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_data = data;
        if (addr < N) mbuf[addr] = data;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic push_frame();
        for (int i = 0; i < N; i++) exp_q.push_back(mbuf[i]);
    endtask

    task automatic pulse_req();
        frame_req = 1'b1;
        req_cyc   = cyc;
        tick();
        frame_req = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 3000) begin
            tick();
            n++;
        end
        check("frame_done reached", done_cnt >= target, 1);
    endtask

    initial begin
        int base_done, base_hs, d1, bad, target, n;
        bit extra;

        for (int i = 0; i < N; i++) mbuf[i] = '0;
        repeat (3) tick();
        check("reset px_valid", px_valid, 0);
        check("reset px_data", px_data, 0);
        check("reset busy", busy, 0);
        check("reset frame_done", frame_done, 0);
        rst_n = 1'b1;
        tick();

        // Pure G, R, B pixels streamed back to back.
        write_px(0, 24'hFF0000);
        write_px(1, 24'h00FF00);
        write_px(2, 24'h0000FF);
        base_hs = hs_cnt; base_done = done_cnt;
        push_frame();
        pulse_req();
        wait_done(base_done + 1);
        check("t1 px_valid latency", rise_cyc, req_cyc + 1);
        check("t1 last handshake cycle", last_hs_cyc, req_cyc + 3);
        check("t1 handshake count", hs_cnt - base_hs, 3);
        // handshake edge, ignored DRAIN entry cycle, DRAIN exit, then LAT latch cycles
        check("t1 done after last handshake", done_cyc - last_hs_cyc, LAT + 3);
        check("t1 px_valid low after frame", px_valid, 0);

        // Stall on pixel 0, update pixel 2 before it is sent, stall again on pixel 1.
        for (int i = 0; i < N; i++) write_px(i, 24'($urandom));
        base_hs = hs_cnt; base_done = done_cnt;
        px_ready = 1'b0;
        exp_q.push_back(mbuf[0]);
        exp_q.push_back(mbuf[1]);
        pulse_req();
        repeat (3) tick();
        write_px(2, 24'h5A5A5A);
        exp_q.push_back(mbuf[2]);
        px_ready = 1'b1;
        tick();
        px_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t2 px_valid held", px_valid, 1);
        end
        px_ready = 1'b1;
        wait_done(base_done + 1);
        check("t2 handshake count", hs_cnt - base_hs, 3);

        // Serializer reports idle 20 cycles after the last handshake.
        base_hs = hs_cnt; base_done = done_cnt;
        ser_idle = 1'b0;
        push_frame();
        pulse_req();
        n = 0;
        while (hs_cnt < base_hs + 3 && n < 200) begin tick(); n++; end
        check("t3 handshakes seen", hs_cnt, base_hs + 3);
        bad = 0;
        while (cyc < last_hs_cyc + 19) begin
            tick();
            if (px_valid) bad++;
        end
        ser_idle = 1'b1;
        n = 0;
        while (done_cnt < base_done + 1 && n < 200) begin
            tick();
            if (px_valid) bad++;
            n++;
        end
        check("t3 frame_done timing", done_cyc - last_hs_cyc, 20 + LAT);
        check("t3 px_valid idle in drain/latch", bad, 0);

        // Three requests during SEND coalesce into one follow-on frame.
        base_hs = hs_cnt; base_done = done_cnt;
        px_ready = 1'b0;
        push_frame();
        pulse_req();
        for (int k = 0; k < 3; k++) begin
            tick();
            frame_req = 1'b1;
            tick();
            frame_req = 1'b0;
        end
        push_frame();
        px_ready = 1'b1;
        wait_done(base_done + 1);
        d1 = done_cyc;
        wait_done(base_done + 2);
        check("t4 follow-on start", rise_cyc, d1 + 1);
        check("t4 handshake count", hs_cnt - base_hs, 6);
        repeat (30) tick();
        check("t4 no third frame", done_cnt, base_done + 2);
        check("t4 idle afterwards", busy, 0);

        // Randomized frames with random back-pressure and extra requests.
        for (int it = 0; it < 12; it++) begin
            n = $urandom_range(0, 4);
            for (int w = 0; w < n; w++) write_px($urandom_range(0, 3), 24'($urandom));
            base_done = done_cnt;
            target = base_done + 1;
            extra = 1'b0;
            push_frame();
            pulse_req();
            n = 0;
            while (done_cnt < target && n < 3000) begin
                px_ready = ($urandom % 4) != 0;
                ser_idle = ($urandom % 3) != 0;
                frame_req = busy && (done_cnt == base_done) && (($urandom % 8) == 0);
                if (frame_req && !extra) begin
                    extra = 1'b1;
                    target = base_done + 2;
                    push_frame();
                end
                tick();
                frame_req = 1'b0;
                n++;
            end
            px_ready = 1'b1;
            ser_idle = 1'b1;
            check("rand frames done", done_cnt, target);
            repeat (5) tick();
            check("rand idle after frames", busy, 0);
        end

        // Refresh-only instance: frames every REF cycles with no requests.
        check("refresh pulses recorded", r_done_cyc.size() >= 4, 1);
        if (r_done_cyc.size() >= 4)
            for (int i = 1; i < 4; i++)
                check("refresh period", r_done_cyc[i] - r_done_cyc[i-1], REF);

        // Reset mid-SEND aborts the frame and clears the buffer.
        for (int i = 0; i < N; i++) write_px(i, 24'($urandom) | 24'h1);
        base_done = done_cnt;
        px_ready = 1'b0;
        pulse_req();
        repeat (3) tick();
        #3 rst_n = 1'b0;
        #1;
        check("async reset px_valid", px_valid, 0);
        check("async reset px_data", px_data, 0);
        check("async reset busy", busy, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) mbuf[i] = '0;
        exp_q.delete();
        px_ready = 1'b1;
        tick();
        write_px(N, 24'hABCDEF);
        push_frame();
        pulse_req();
        wait_done(base_done + 1);
        check("no frame_done from aborted frame", done_cnt, base_done + 1);
        repeat (3) tick();
        check("scoreboard drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
